// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares the eight-digit seven-segment display with a minimum dwell per grant.
// Optional leading-zero blanking of digit_en is enabled by defining DISP_BLANK_EN.
module display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int CW          = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   val_in,
    input  logic                 freeze,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          disp_val,
    output logic [2:0]           disp_src,
    output logic                 busy,
    output logic [7:0]           digit_en
);

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CW-1:0] CNT_MAX   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    LAST_INIT = 3'(NREQ - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      last_q, last_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [31:0]     val_q, val_d;
    logic [2:0]      src_q, src_d;
    logic            busy_q, busy_d;
    logic [7:0]      den_q, den_d;

    logic [7:0]      req8_s;
    logic            any_s;
    logic [2:0]      win_s;
    logic            expire_s;
    logic            load_s;
    logic [2:0]      sel_s;

`ifdef DISP_BLANK_EN
    // Enable every digit up to the most-significant nonzero nibble; digit 0 always shows.
    function automatic logic [7:0] blank_mask(input logic [31:0] v);
        logic [7:0] m;
        int         msn;
        msn = 0;
        for (int k = 0; k < 8; k++) begin
            if (v[4*k +: 4] != 4'h0) msn = k;
        end
        for (int k = 0; k < 8; k++) begin
            m[k] = (k <= msn);
        end
        return m;
    endfunction
`endif

    // Zero-extend the request vector so a 3-bit owner index can address it safely.
    always_comb begin
        req8_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            req8_s[i] = req[i];
        end
    end

    // Round-robin pick: first requester scanning upward from last_grant+1, wrapping.
    always_comb begin
        any_s = 1'b0;
        win_s = 3'd0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_s && req8_s[3'((int'(last_q) + i) % NREQ)]) begin
                any_s = 1'b1;
                win_s = 3'((int'(last_q) + i) % NREQ);
            end else begin
                any_s = any_s;
            end
        end
    end

    assign expire_s = (cnt_q == CNT_MAX) && !freeze;

    // Next-state and registered-output logic for the IDLE/HOLD machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack_d   = '0;
        val_d   = val_q;
        src_d   = src_q;
        busy_d  = busy_q;
        load_s  = 1'b0;
        sel_s   = src_q;

        case (state_q)
            IDLE: begin
                if (any_s) begin
                    load_s = 1'b1;
                    sel_s  = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (expire_s) begin
                    if (any_s) begin
                        load_s = 1'b1;
                        sel_s  = win_s;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    // Refresh does not restart the dwell, so a live owner cannot starve others.
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    if (req8_s[src_q]) begin
                        load_s = 1'b1;
                        sel_s  = src_q;
                    end else begin
                        load_s = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (load_s && (sel_s != src_q || state_q == IDLE || expire_s)) begin
            state_d = HOLD;
            cnt_d   = '0;
            last_d  = sel_s;
            src_d   = sel_s;
            busy_d  = 1'b1;
        end else begin
            last_d = last_d;
        end

        for (int i = 0; i < NREQ; i++) begin
            if (load_s && (3'(i) == sel_s)) begin
                ack_d[i] = 1'b1;
                val_d    = val_in[32*i +: 32];
            end else begin
                ack_d[i] = 1'b0;
            end
        end

`ifdef DISP_BLANK_EN
        if (load_s) begin
            den_d = blank_mask(val_d);
        end else begin
            den_d = den_q;
        end
`else
        den_d = 8'hFF;
`endif
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_INIT;
            ack_q   <= '0;
            val_q   <= 32'h0000_0000;
            src_q   <= 3'd0;
            busy_q  <= 1'b0;
            den_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            val_q   <= val_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
            den_q   <= den_d;
        end
    end

    assign ack      = ack_q;
    assign disp_val = val_q;
    assign disp_src = src_q;
    assign busy     = busy_q;
    assign digit_en = den_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed, table-driven bench for display_arbiter with NREQ=4 and HOLD_CYCLES=4.
module tb_display_arbiter;

    localparam int NREQ = 4;
`ifdef DISP_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic              clock;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*32-1:0] val_in;
    logic              freeze;
    logic [NREQ-1:0]   ack;
    logic [31:0]       disp_val;
    logic [2:0]        disp_src;
    logic              busy;
    logic [7:0]        digit_en;

    logic [31:0] vals [4];
    logic [7:0]  den_of [4];
    int checks;
    int failures;

    assign val_in = {vals[3], vals[2], vals[1], vals[0]};

    display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(4), .CW(8)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .val_in(val_in), .freeze(freeze),
        .ack(ack), .disp_val(disp_val), .disp_src(disp_src), .busy(busy), .digit_en(digit_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [31:0] val;
        logic [2:0]  src;
        logic        busy;
        logic [7:0]  den;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [7:0] den_exp(input logic [7:0] blanked);
        return BLANK ? blanked : 8'hFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        freeze  = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vals[0] = 32'h0000_0000; den_of[0] = 8'h01;
        vals[1] = 32'h0000_12AB; den_of[1] = 8'h0F;
        vals[2] = 32'hDEAD_BEEF; den_of[2] = 8'hFF;
        vals[3] = 32'h8000_0000; den_of[3] = 8'hFF;

        tbl[0] = '{4'b0100, 4'b0100, 32'hDEAD_BEEF, 3'd2, 1'b1, 8'hFF};
        tbl[1] = '{4'b0000, 4'b0000, 32'hDEAD_BEEF, 3'd2, 1'b1, 8'hFF};
        tbl[2] = '{4'b0000, 4'b0000, 32'hDEAD_BEEF, 3'd2, 1'b1, 8'hFF};
        tbl[3] = '{4'b0000, 4'b0000, 32'hDEAD_BEEF, 3'd2, 1'b1, 8'hFF};
        tbl[4] = '{4'b0000, 4'b0000, 32'hDEAD_BEEF, 3'd2, 1'b0, 8'hFF};
        tbl[5] = '{4'b0000, 4'b0000, 32'hDEAD_BEEF, 3'd2, 1'b0, 8'hFF};
        tbl[6] = '{4'b1011, 4'b1000, 32'h8000_0000, 3'd3, 1'b1, 8'hFF};

        reset_n = 1'b1;
        req     = 4'b0000;
        freeze  = 1'b0;
        #1;
        do_reset();
        chk("rst_ack",  32'(ack), 32'h0);
        chk("rst_val",  disp_val, 32'h0);
        chk("rst_src",  32'(disp_src), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_den",  32'(digit_en), 32'hFF);

        // Single grant, expiry to IDLE, then a round-robin pick starting after source 2.
        for (int v = 0; v < 7; v++) begin
            req = tbl[v].req;
            tick();
            chk($sformatf("tbl%0d_ack", v),  32'(ack), 32'(tbl[v].ack));
            chk($sformatf("tbl%0d_val", v),  disp_val, tbl[v].val);
            chk($sformatf("tbl%0d_src", v),  32'(disp_src), 32'(tbl[v].src));
            chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
            chk($sformatf("tbl%0d_den", v),  32'(digit_en), 32'(tbl[v].den));
        end

        // Asynchronous reset in the middle of HOLD, observed before any clock edge.
        req = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_ack",  32'(ack), 32'h0);
        chk("async_val",  disp_val, 32'h0);
        chk("async_src",  32'(disp_src), 32'h0);
        chk("async_den",  32'(digit_en), 32'hFF);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_ack",  32'(ack), 32'h0);
            chk("idle_val",  disp_val, 32'h0);
            chk("idle_den",  32'(digit_en), 32'hFF);
        end

        // Full contention: owners rotate 0,1,2,3,0 every 4 cycles, refreshing in between.
        req = 4'b1111;
        for (int c = 0; c < 17; c++) begin
            int s;
            s = (c / 4) % 4;
            tick();
            chk($sformatf("rr%0d_src", c),  32'(disp_src), 32'(s));
            chk($sformatf("rr%0d_ack", c),  32'(ack), 32'(4'b0001 << s));
            chk($sformatf("rr%0d_busy", c), 32'(busy), 32'h1);
            chk($sformatf("rr%0d_val", c),  disp_val, vals[s]);
            chk($sformatf("rr%0d_den", c),  32'(digit_en), 32'(den_exp(den_of[s])));
        end

        // Owner 1 refreshes with a changing value; source 3 still wins after the dwell.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            vals[1] = 32'h0000_0100 + 32'(c);
            req = (c == 0) ? 4'b0010 : 4'b1010;
            tick();
            if (c < 4) begin
                chk($sformatf("ref%0d_ack", c), 32'(ack), 32'h2);
                chk($sformatf("ref%0d_val", c), disp_val, 32'h0000_0100 + 32'(c));
                chk($sformatf("ref%0d_den", c), 32'(digit_en), 32'(den_exp(8'h07)));
            end else begin
                chk("ref4_ack", 32'(ack), 32'h8);
                chk("ref4_src", 32'(disp_src), 32'h3);
                chk("ref4_val", disp_val, 32'h8000_0000);
            end
        end
        vals[1] = 32'h0000_12AB;

        // Freeze holds owner 0 indefinitely; releasing it hands over on the next edge.
        do_reset();
        req = 4'b0001;
        tick();
        chk("frz_grant", 32'(ack), 32'h1);
        req    = 4'b0010;
        freeze = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("frz_src",  32'(disp_src), 32'h0);
            chk("frz_ack",  32'(ack), 32'h0);
            chk("frz_busy", 32'(busy), 32'h1);
        end
        freeze = 1'b0;
        tick();
        chk("unfrz_ack", 32'(ack), 32'h2);
        chk("unfrz_src", 32'(disp_src), 32'h1);
        chk("unfrz_val", disp_val, 32'h0000_12AB);
        chk("unfrz_den", 32'(digit_en), 32'(den_exp(8'h0F)));

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
